// File: rtl/cond_pkg.sv
// Shared condition-code definitions for the NZCV flag register and its users.
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
      MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
      HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
      GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [1:0] FLAGW_NZ = 2'b10;
   localparam logic [1:0] FLAGW_CV = 2'b01;

endpackage

// File: rtl/cond_logic_check.sv
// Combinational ARM condition evaluator: (cond, NZCV) -> condition passed.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       cond_ex_o
);

   logic n, z, c, v;

   assign n = flags_i[FLAG_N];
   assign z = flags_i[FLAG_Z];
   assign c = flags_i[FLAG_C];
   assign v = flags_i[FLAG_V];

   always_comb begin
      cond_ex_o = 1'b0;
      case (cond_e'(cond_i))
         EQ: cond_ex_o = z;
         NE: cond_ex_o = ~z;
         CS: cond_ex_o = c;
         CC: cond_ex_o = ~c;
         MI: cond_ex_o = n;
         PL: cond_ex_o = ~n;
         VS: cond_ex_o = v;
         VC: cond_ex_o = ~v;
         HI: cond_ex_o = c & ~z;
         LS: cond_ex_o = ~c | z;
         GE: cond_ex_o = n ~^ v;
         LT: cond_ex_o = n ^ v;
         GT: cond_ex_o = ~z & (n ~^ v);
         LE: cond_ex_o = z | (n ^ v);
         AL: cond_ex_o = 1'b1;
         NV: cond_ex_o = 1'b0;
         default: cond_ex_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag register plus condition gating of the decoder's write/branch requests.
module cond_logic
   import cond_pkg::*;
#(
   parameter bit         MULTICYCLE  = 1'b0,
   parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Cond,
   input  logic [3:0] ALUFlags,
   input  logic [1:0] FlagW,
   input  logic       PCS,
   input  logic       RegW,
   input  logic       MemW,
   input  logic       NoWrite,
   input  logic       CondLatch,
   output logic       PCSrc,
   output logic       RegWrite,
   output logic       MemWrite,
   output logic [3:0] Flags,
   output logic       CondEx
);

   logic [3:0] flags_q, flags_d;
   logic       condexr_q, condexr_d;
   logic       cond_ex_eff;
   logic [1:0] flag_write;

   // Evaluated against the stored flags, so an instruction never sees its own update.
   cond_check u_check (
      .cond_i    (Cond),
      .flags_i   (flags_q),
      .cond_ex_o (CondEx)
   );

   assign cond_ex_eff = MULTICYCLE ? condexr_q : CondEx;
   assign flag_write  = FlagW & {2{cond_ex_eff}};

   always_comb begin
      flags_d = flags_q;
      if (flag_write[1]) flags_d[FLAG_N:FLAG_Z] = ALUFlags[FLAG_N:FLAG_Z];
      if (flag_write[0]) flags_d[FLAG_C:FLAG_V] = ALUFlags[FLAG_C:FLAG_V];
   end

   always_comb begin
      condexr_d = condexr_q;
      if (MULTICYCLE && CondLatch) condexr_d = CondEx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags_q   <= RESET_FLAGS;
         condexr_q <= 1'b0;
      end else begin
         flags_q   <= flags_d;
         condexr_q <= condexr_d;
      end
   end

   assign PCSrc    = PCS & cond_ex_eff;
   assign RegWrite = RegW & ~NoWrite & cond_ex_eff;
   assign MemWrite = MemW & cond_ex_eff;
   assign Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench: single-cycle instance (s_*) and multicycle instance (m_*).
module tb_cond_logic;

   logic clk = 1'b0;
   logic reset;

   logic [3:0] s_cond, s_aluf, s_flags;
   logic [1:0] s_flagw;
   logic       s_pcs, s_regw, s_memw, s_nowr, s_latch;
   logic       s_pcsrc, s_regwr, s_memwr, s_condex;

   logic [3:0] m_cond, m_aluf, m_flags;
   logic [1:0] m_flagw;
   logic       m_pcs, m_regw, m_memw, m_nowr, m_latch;
   logic       m_pcsrc, m_regwr, m_memwr, m_condex;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cond_logic #(.MULTICYCLE(1'b0), .RESET_FLAGS(4'b0000)) u_sc (
      .clk(clk), .reset(reset), .Cond(s_cond), .ALUFlags(s_aluf), .FlagW(s_flagw),
      .PCS(s_pcs), .RegW(s_regw), .MemW(s_memw), .NoWrite(s_nowr), .CondLatch(s_latch),
      .PCSrc(s_pcsrc), .RegWrite(s_regwr), .MemWrite(s_memwr), .Flags(s_flags), .CondEx(s_condex)
   );

   cond_logic #(.MULTICYCLE(1'b1), .RESET_FLAGS(4'b0100)) u_mc (
      .clk(clk), .reset(reset), .Cond(m_cond), .ALUFlags(m_aluf), .FlagW(m_flagw),
      .PCS(m_pcs), .RegW(m_regw), .MemW(m_memw), .NoWrite(m_nowr), .CondLatch(m_latch),
      .PCSrc(m_pcsrc), .RegWrite(m_regwr), .MemWrite(m_memwr), .Flags(m_flags), .CondEx(m_condex)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Base condition per pair of codes; odd code inverts it (AL/NV pair included).
   function automatic bit exp_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, r;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cy;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cy && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      return c[0] ? !r : r;
   endfunction

   initial begin
      reset = 1'b1;
      s_cond = 4'hE; s_aluf = 4'b0100; s_flagw = 2'b11;
      s_pcs = 0; s_regw = 0; s_memw = 0; s_nowr = 0; s_latch = 0;
      m_cond = 4'hE; m_aluf = 4'b0000; m_flagw = 2'b00;
      m_pcs = 1; m_regw = 1; m_memw = 1; m_nowr = 0; m_latch = 0;

      // Reset behaviour
      tick();
      chk("sc_reset_flags", s_flags, 4'b0000);
      chk("mc_reset_flags", m_flags, 4'b0100);
      chk("mc_reset_enables", {m_pcsrc, m_regwr, m_memwr}, 3'b000);
      reset = 1'b0;
      tick();
      chk("sc_first_write", s_flags, 4'b0100);

      // Condition gating on Z=1
      s_flagw = 2'b00; s_cond = 4'h0; s_regw = 1; s_memw = 1; s_pcs = 1;
      #1;
      chk("eq_regwrite", s_regwr, 1'b1);
      chk("eq_memwrite", s_memwr, 1'b1);
      chk("eq_pcsrc", s_pcsrc, 1'b1);
      s_nowr = 1;
      #1;
      chk("nowrite_regwrite", s_regwr, 1'b0);
      s_nowr = 0;
      s_cond = 4'h1; s_flagw = 2'b11; s_aluf = 4'b1011;
      #1;
      chk("ne_regwrite", s_regwr, 1'b0);
      chk("ne_memwrite", s_memwr, 1'b0);
      chk("ne_pcsrc", s_pcsrc, 1'b0);
      tick();
      chk("ne_flags_held", s_flags, 4'b0100);

      // Independent group writes
      s_cond = 4'hE; s_flagw = 2'b11; s_aluf = 4'b0000;
      tick();
      chk("clear_flags", s_flags, 4'b0000);
      s_flagw = 2'b01; s_aluf = 4'b1111;
      tick();
      chk("cv_only", s_flags, 4'b0011);
      s_flagw = 2'b10; s_aluf = 4'b1000;
      tick();
      chk("nz_only", s_flags, 4'b1011);
      s_flagw = 2'b00; s_aluf = 4'bxxxx;
      tick();
      chk("x_aluflags_held", s_flags, 4'b1011);

      // Full condition sweep
      s_regw = 0; s_memw = 0; s_pcs = 0;
      for (int f = 0; f < 16; f++) begin
         s_cond = 4'hE; s_flagw = 2'b11; s_aluf = 4'(f);
         tick();
         s_flagw = 2'b00;
         for (int c = 0; c < 16; c++) begin
            s_cond = 4'(c);
            #1;
            chk($sformatf("sweep_c%0h_f%0h", c, f), s_condex, exp_cond(4'(c), 4'(f)));
         end
      end

      // Multicycle: latched condition sees old flags
      m_flagw = 2'b11; m_aluf = 4'b1111;
      tick();
      chk("mc_no_write_unlatched", m_flags, 4'b0100);
      m_cond = 4'hE; m_latch = 1; m_flagw = 2'b00;
      tick();
      chk("mc_latch_al", m_pcsrc, 1'b1);
      m_cond = 4'h0; m_latch = 1; m_flagw = 2'b11; m_aluf = 4'b0000;
      #1;
      chk("mc_condex_old_z", m_condex, 1'b1);
      tick();
      m_latch = 0; m_flagw = 2'b00;
      #1;
      chk("mc_flags_updated", m_flags, 4'b0000);
      chk("mc_condex_now", m_condex, 1'b0);
      chk("mc_pcsrc_held", m_pcsrc, 1'b1);
      tick();
      chk("mc_pcsrc_held2", m_pcsrc, 1'b1);
      chk("mc_regwrite_held", m_regwr, 1'b1);
      m_latch = 1;
      tick();
      m_latch = 0;
      chk("mc_latch_fail", {m_pcsrc, m_regwr, m_memwr}, 3'b000);

      // Reset overrides pending latch/flag write
      m_cond = 4'hE; m_latch = 1;
      tick();
      chk("mc_relatch", m_pcsrc, 1'b1);
      reset = 1; m_flagw = 2'b11; m_aluf = 4'b1011; m_latch = 1;
      tick();
      reset = 0; m_latch = 0;
      chk("mc_reset_flags2", m_flags, 4'b0100);
      chk("mc_reset_enables2", {m_pcsrc, m_regwr, m_memwr}, 3'b000);
      tick();
      chk("mc_post_reset_flags", m_flags, 4'b0100);
      chk("mc_post_reset_enables", {m_pcsrc, m_regwr, m_memwr}, 3'b000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
